pipelined_shifter: RTL and testbench

- Parametrised, pipelined multi-mode barrel shifter for the ALU datapath: logical left, logical right, arithmetic right, rotate right.
- Generalises the fixed 32-bit combinational left shifter to any power-of-two width.
- One register rank per log2 shift stage, with valid/ready handshakes on both sides.
- Throughput is one operation per cycle; a tag field is carried alongside each operation for result routing.

---
 rtl/pipelined_shifter.sv | 149 ++++++++++++++
 tb/tb_pipelined_shifter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_shifter.sv
// Pipelined multi-mode barrel shifter: SLL, SRL, SRA, ROR.
// One register rank per shift-amount bit; stage k shifts by 2^k when that bit is set.
// Valid/ready on both sides; the whole pipeline freezes while the output is stalled.
// Optional feature macro: SHIFTER_CARRY_EN adds out_carry (last bit shifted out).
module pipelined_shifter #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic [TAG_W-1:0]   out_tag
`ifdef SHIFTER_CARRY_EN
  ,
  output logic               out_carry
`endif
);

  localparam int LAST = SHAMT_W - 1;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  logic stall;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    localparam int S = 1 << k;

    logic                 valid_d;
    logic                 valid_q;
    logic [WIDTH-1:0]     data_d;
    logic [WIDTH-1:0]     data_q;
    logic [WIDTH-1:0]     shifted;
    op_e                  op_d;
    logic                 sign_d;
    logic [SHAMT_W-1:k]   shamt_d;
    logic [TAG_W-1:0]     tag_d;
    logic [TAG_W-1:0]     tag_q;
`ifdef SHIFTER_CARRY_EN
    logic                 carry_d;
    logic                 carry_q;
    logic                 carry_nx;
`endif

    if (k == 0) begin : g_src
      assign valid_d = in_valid;
      assign data_d  = in_a;
      assign op_d    = op_e'(in_op);
      assign sign_d  = in_a[WIDTH-1];
      assign shamt_d = in_shamt;
      assign tag_d   = in_tag;
`ifdef SHIFTER_CARRY_EN
      assign carry_d = 1'b0;
`endif
    end else begin : g_src
      assign valid_d = g_stage[k-1].valid_q;
      assign data_d  = g_stage[k-1].data_q;
      assign op_d    = g_stage[k-1].g_ctl.op_q;
      assign sign_d  = g_stage[k-1].g_ctl.sign_q;
      assign shamt_d = g_stage[k-1].g_ctl.rem_q;
      assign tag_d   = g_stage[k-1].tag_q;
`ifdef SHIFTER_CARRY_EN
      assign carry_d = g_stage[k-1].carry_q;
`endif
    end

    // Conditional shift by 2^k with per-op fill; the carry is tracked incrementally,
    // since the last bit out of this stage maps back to the original operand bit.
    always_comb begin
      shifted = data_d;
`ifdef SHIFTER_CARRY_EN
      carry_nx = carry_d;
`endif
      if (shamt_d[k]) begin
        case (op_d)
          OP_SLL:  shifted = {data_d[WIDTH-1-S:0], {S{1'b0}}};
          OP_SRL:  shifted = {{S{1'b0}}, data_d[WIDTH-1:S]};
          OP_SRA:  shifted = {{S{sign_d}}, data_d[WIDTH-1:S]};
          OP_ROR:  shifted = {data_d[S-1:0], data_d[WIDTH-1:S]};
          default: shifted = data_d;
        endcase
`ifdef SHIFTER_CARRY_EN
        carry_nx = (op_d == OP_SLL) ? data_d[WIDTH-S] : data_d[S-1];
`endif
      end
    end

    // Valid, data and tag rank: cleared by reset, frozen during a stall.
    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        tag_q   <= '0;
`ifdef SHIFTER_CARRY_EN
        carry_q <= 1'b0;
`endif
      end else if (!stall) begin
        valid_q <= valid_d;
        if (valid_d) begin
          data_q  <= shifted;
          tag_q   <= tag_d;
`ifdef SHIFTER_CARRY_EN
          carry_q <= carry_nx;
`endif
        end
      end
    end

    // The output rank has no further stages, so op/sign/remaining shamt stop before it.
    if (k < LAST) begin : g_ctl
      op_e                  op_q;
      logic                 sign_q;
      logic [SHAMT_W-1:k+1] rem_q;

      // Control rank: only meaningful alongside valid_q, so no reset is needed.
      always_ff @(posedge clk) begin
        if (!stall && valid_d) begin
          op_q   <= op_d;
          sign_q <= sign_d;
          rem_q  <= shamt_d[SHAMT_W-1:k+1];
        end
      end
    end
  end

  assign out_valid  = g_stage[LAST].valid_q;
  assign out_result = g_stage[LAST].data_q;
  assign out_tag    = g_stage[LAST].tag_q;
`ifdef SHIFTER_CARRY_EN
  assign out_carry  = g_stage[LAST].carry_q;
`endif

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed self-checking bench for pipelined_shifter (WIDTH=32 plus a WIDTH=16 instance).
// Define SHIFTER_CARRY_EN for both files to also check out_carry.
module tb_pipelined_shifter;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_tag;

  logic        in_valid16;
  logic        in_ready16;
  logic [15:0] in_a16;
  logic [3:0]  in_shamt16;
  logic [1:0]  in_op16;
  logic [3:0]  in_tag16;
  logic        out_valid16;
  logic [15:0] out_result16;
  logic [3:0]  out_tag16;
`ifdef SHIFTER_CARRY_EN
  logic        out_carry;
  logic        out_carry16;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_shifter #(.WIDTH(32), .TAG_W(4)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_shamt(in_shamt),
    .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag)
`ifdef SHIFTER_CARRY_EN
    , .out_carry(out_carry)
`endif
  );

  pipelined_shifter #(.WIDTH(16), .TAG_W(4)) u_dut16 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid16), .in_ready(in_ready16), .in_a(in_a16), .in_shamt(in_shamt16),
    .in_op(in_op16), .in_tag(in_tag16),
    .out_valid(out_valid16), .out_ready(1'b1), .out_result(out_result16), .out_tag(out_tag16)
`ifdef SHIFTER_CARRY_EN
    , .out_carry(out_carry16)
`endif
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  sh;
    logic [3:0]  tag;
    logic [31:0] res;
    logic        c;
  } vec_t;

  vec_t vecs [14] = '{
    '{2'd0, 32'h00000001, 5'd31, 4'd3,  32'h80000000, 1'b0},
    '{2'd2, 32'h80000000, 5'd4,  4'd1,  32'hF8000000, 1'b0},
    '{2'd1, 32'hF0000000, 5'd28, 4'd2,  32'h0000000F, 1'b0},
    '{2'd3, 32'h12345678, 5'd8,  4'd4,  32'h78123456, 1'b0},
    '{2'd0, 32'h12345678, 5'd0,  4'd5,  32'h12345678, 1'b0},
    '{2'd1, 32'h12345678, 5'd0,  4'd6,  32'h12345678, 1'b0},
    '{2'd2, 32'h12345678, 5'd0,  4'd7,  32'h12345678, 1'b0},
    '{2'd3, 32'h12345678, 5'd0,  4'd8,  32'h12345678, 1'b0},
    '{2'd2, 32'h7F000000, 5'd4,  4'd9,  32'h07F00000, 1'b0},
    '{2'd3, 32'h00000001, 5'd1,  4'd10, 32'h80000000, 1'b1},
    '{2'd0, 32'h12345678, 5'd4,  4'd11, 32'h23456780, 1'b1},
    '{2'd0, 32'h80000001, 5'd1,  4'd12, 32'h00000002, 1'b1},
    '{2'd1, 32'h00000002, 5'd1,  4'd13, 32'h00000001, 1'b0},
    '{2'd1, 32'h00000003, 5'd1,  4'd14, 32'h00000001, 1'b1}
  };

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One isolated operation with out_ready high; latency counted from the accept edge.
  task automatic run_op(input string n, input vec_t v);
    int lat;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = v.op;
    in_a      = v.a;
    in_shamt  = v.sh;
    in_tag    = v.tag;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = 'x;
    in_shamt = 'x;
    in_op    = 'x;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({n, "_lat"}, 64'(lat), 64'd5);
    check({n, "_res"}, 64'(out_result), 64'(v.res));
    check({n, "_tag"}, 64'(out_tag), 64'(v.tag));
`ifdef SHIFTER_CARRY_EN
    check({n, "_carry"}, 64'(out_carry), 64'(v.c));
`endif
  endtask

  initial begin
    int lat;
    int sent;
    int got;
    int last_c;
    int stall_n;
    int stale;
    logic accept;

    reset = 1'b1;
    in_valid = 1'b0; in_a = '0; in_shamt = '0; in_op = '0; in_tag = '0; out_ready = 1'b1;
    in_valid16 = 1'b0; in_a16 = '0; in_shamt16 = '0; in_op16 = '0; in_tag16 = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(out_result), 64'd0);
    check("rst_tag", 64'(out_tag), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 14; i++) run_op($sformatf("v%0d", i), vecs[i]);

    // WIDTH=16: SLL 1 by 15 -> 0x8000 after 4 cycles.
    @(negedge clk);
    in_valid16 = 1'b1; in_a16 = 16'h0001; in_shamt16 = 4'd15; in_op16 = 2'd0; in_tag16 = 4'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid16 = 1'b0;
    lat = 1;
    while (!out_valid16 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("w16_lat", 64'(lat), 64'd4);
    check("w16_res", 64'(out_result16), 64'h8000);
    check("w16_tag", 64'(out_tag16), 64'd3);
`ifdef SHIFTER_CARRY_EN
    check("w16_carry", 64'(out_carry16), 64'd0);
`endif

    // Backpressure: 8 back-to-back SLL of 3 by 3*i, out_ready low for cycles 6..8.
    repeat (3) @(negedge clk);
    sent = 0; got = 0; last_c = -1; stall_n = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(negedge clk);
      out_ready = !(c >= 6 && c <= 8);
      if (sent < 8) begin
        in_valid = 1'b1;
        in_op    = 2'd0;
        in_a     = 32'h3;
        in_shamt = 5'(sent * 3);
        in_tag   = 4'(sent);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      check("bp_in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (out_valid && !out_ready) stall_n++;
      if (out_valid && out_ready) begin
        check("bp_tag", 64'(out_tag), 64'(got));
        check("bp_res", 64'(out_result), 64'(32'h3 << (3 * got)));
        got++;
        last_c = c;
      end
      accept = in_valid && in_ready;
      @(posedge clk);
      if (accept) sent++;
    end
    check("bp_delivered", 64'(got), 64'd8);
    check("bp_stalls", 64'(stall_n), 64'd3);
    check("bp_last_cycle", 64'(last_c), 64'd15);

    // Reset with 3 operations in flight.
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_op = 2'd3; in_a = 32'hA5A5F00F; in_shamt = 5'(i + 1); in_tag = 4'(9 + i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst3_valid", 64'(out_valid), 64'd0);
    check("rst3_result", 64'(out_result), 64'd0);
    check("rst3_tag", 64'(out_tag), 64'd0);
    check("rst3_in_ready", 64'(in_ready), 64'd1);
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("rst3_stale", 64'(stale), 64'd0);

    // Reset while the output stage is stalled.
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 2'd0; in_a = 32'h1; in_shamt = 5'd31; in_tag = 4'd5;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("stall_valid", 64'(out_valid), 64'd1);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    check("stall_res", 64'(out_result), 64'h80000000);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rsts_valid", 64'(out_valid), 64'd0);
    check("rsts_result", 64'(out_result), 64'd0);
    check("rsts_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("rsts_stale", 64'(stale), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
